// File: rtl/dma_burst_streamer_if.sv
// dma_burst_streamer_if: descriptor input, status outputs and the burst request handshake of one DMA side.
interface dma_burst_streamer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 32
);
  logic                  start_i;
  logic [ADDR_W-1:0]     desc_addr_i;
  logic [LEN_W-1:0]      desc_bytes_i;
  logic                  desc_mode_i;
  logic                  abort_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  req_valid_o;
  logic [ADDR_W-1:0]     req_addr_o;
  logic [7:0]            req_alen_o;
  logic [2:0]            req_size_o;
  logic [DATA_W/8-1:0]   req_strb_o;
  logic                  req_mode_o;
  logic                  req_ready_i;
  modport master (
    input  start_i, desc_addr_i, desc_bytes_i, desc_mode_i, abort_i, req_ready_i,
    output busy_o, done_o, req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o, req_mode_o
  );
  modport slave (
    output start_i, desc_addr_i, desc_bytes_i, desc_mode_i, abort_i, req_ready_i,
    input  busy_o, done_o, req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o, req_mode_o
  );
endinterface

// File: rtl/dma_burst_streamer.sv
// dma_burst_streamer: splits a DMA descriptor into AXI-legal bursts, each with one strobe valid for all beats.
module dma_burst_streamer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = 32
) (
  input logic clk,
  input logic rst,
  dma_burst_streamer_if.master bus
);
  localparam int BPB = DATA_W / 8;
  localparam int SZ  = $clog2(BPB);
  typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr, r_req_addr;
  logic [LEN_W-1:0]  r_left, r_n;
  logic              r_mode, r_abort, r_valid, r_done, r_req_mode;
  logic [7:0]        r_alen;
  logic [2:0]        r_size;
  logic [BPB-1:0]    r_strb;
  logic [ADDR_W-1:0] w_off;
  logic [12:0]       w_pg;
  logic [LEN_W-1:0]  w_room, w_lim, w_beats, w_n;
  logic [BPB-1:0]    w_mask, w_strb;
  logic              w_head, w_tail, w_fin;
  // Partial beats (unaligned head or short tail) go out alone so the strobe fits every beat.
  always_comb begin
    w_off   = r_addr & ADDR_W'(BPB - 1);
    w_room  = LEN_W'(BPB) - LEN_W'(w_off);
    w_pg    = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;
    w_lim   = (r_left >> SZ) > LEN_W'(MAX_BEATS) ? LEN_W'(MAX_BEATS) : r_left >> SZ;
    w_beats = r_mode && w_lim > LEN_W'(w_pg) ? LEN_W'(w_pg) : w_lim;
    w_head  = w_off != '0;
    w_tail  = !w_head && r_left < LEN_W'(BPB);
    w_n     = w_head ? (r_left < w_room ? r_left : w_room) : w_tail ? r_left : w_beats << SZ;
    w_mask  = ~({BPB{1'b1}} << w_n);
    w_strb  = w_head || w_tail ? w_mask << w_off : '1;
    w_fin   = r_left == r_n || r_abort || bus.abort_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_left     <= '0;
      r_n        <= '0;
      r_mode     <= 1'b0;
      r_abort    <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_req_addr <= '0;
      r_alen     <= '0;
      r_size     <= '0;
      r_strb     <= '0;
      r_req_mode <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && bus.abort_i) r_abort <= 1'b1;
      case (r_state)
        IDLE: if (bus.start_i) begin
          r_addr  <= bus.desc_addr_i;
          r_left  <= bus.desc_bytes_i;
          r_mode  <= bus.desc_mode_i;
          r_state <= bus.desc_bytes_i == '0 ? DONE : CALC;
          r_done  <= bus.desc_bytes_i == '0;
        end
        CALC: if (r_abort || bus.abort_i) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_state    <= REQ;
          r_valid    <= 1'b1;
          r_req_addr <= r_addr - w_off;
          r_alen     <= w_head || w_tail ? 8'd0 : 8'(w_beats - LEN_W'(1));
          r_size     <= 3'(SZ);
          r_strb     <= w_strb;
          r_req_mode <= r_mode;
          r_n        <= w_n;
        end
        REQ: if (bus.req_ready_i) begin
          r_valid <= 1'b0;
          r_left  <= r_left - r_n;
          if (r_mode) r_addr <= r_addr + ADDR_W'(r_n);
          r_state <= w_fin ? DONE : CALC;
          r_done  <= w_fin;
        end
        default: begin
          r_abort <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy_o      = r_state != IDLE;
  assign bus.done_o      = r_done;
  assign bus.req_valid_o = r_valid;
  assign bus.req_addr_o  = r_req_addr;
  assign bus.req_alen_o  = r_alen;
  assign bus.req_size_o  = r_size;
  assign bus.req_strb_o  = r_strb;
  assign bus.req_mode_o  = r_req_mode;
endmodule

// File: tb/tb_dma_burst_streamer.sv
// tb_dma_burst_streamer: random and directed descriptors checked every cycle against a queue-based request model.
module tb_dma_burst_streamer;
  localparam int ADDR_W = 32, DATA_W = 32, MAX_BEATS = 16, LEN_W = 32;
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [3:0]  strb;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  req_t exp_q[$];
  int   errors = 0, checks = 0, cyc = 0, t_ev = 0, dones = 0;
  bit   cur_mode, expect_done, ab_pend, ab_calc, prev_valid, prev_hs, prev_done;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  dma_burst_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
  dma_burst_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  function automatic logic [43:0] pk(req_t r);
    return {r.addr, r.alen, r.strb};
  endfunction
  // Expected request list: partial head/tail bytes singly, whole beats in page- and length-limited chunks.
  function automatic void build(logic [31:0] a, logic [31:0] b, bit m);
    longint cur = a, left = b, off, n, beats, pg;
    req_t r;
    exp_q.delete();
    while (left > 0) begin
      off = cur % 4;
      if (off != 0 || left < 4) begin
        n = (4 - off < left) ? 4 - off : left;
        r.strb = 4'(((longint'(1) << n) - 1) << off);
        r.alen = 8'd0;
      end else begin
        beats = left / 4;
        if (beats > MAX_BEATS) beats = MAX_BEATS;
        pg = (4096 - cur % 4096) / 4;
        if (m && beats > pg) beats = pg;
        n = beats * 4;
        r.strb = 4'hF;
        r.alen = 8'(beats - 1);
      end
      r.addr = 32'(cur - off);
      exp_q.push_back(r);
      left -= n;
      if (m) cur = (cur + n) & 64'hFFFF_FFFF;
    end
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      expect_done = 0;
      prev_valid = 0;
      prev_hs = 0;
      prev_done = 0;
      ab_pend = 0;
    end else begin
      if (prev_valid && !prev_hs) chk("valid_hold", bus.req_valid_o, 1);
      if (!bus.busy_o) chk("idle_no_valid", bus.req_valid_o, 0);
      if (bus.start_i && !bus.busy_o) begin
        t_ev = cyc;
        ab_calc = 0;
        ab_pend = 0;
      end
      if (bus.done_o) begin
        chk("done_expected", expect_done, 1);
        chk("done_left", exp_q.size(), 0);
        if (!ab_calc) chk("lat_done", cyc - t_ev, 1);
        chk("done_busy", bus.busy_o, 1);
        chk("done_width", prev_done, 0);
        expect_done = 0;
        dones++;
      end
      prev_done = bus.done_o;
      if (bus.abort_i && bus.busy_o) begin
        if (bus.req_valid_o) ab_pend = 1;
        else begin
          exp_q.delete();
          ab_calc = 1;
        end
      end
      if (bus.req_valid_o) begin
        if (!prev_valid) chk("lat_req", cyc - t_ev, 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_req: got addr %0h alen %0h, want no request", bus.req_addr_o, bus.req_alen_o);
        end else begin
          chk("req_addr_alen_strb", {bus.req_addr_o, bus.req_alen_o, bus.req_strb_o}, pk(exp_q[0]));
          chk("req_size", bus.req_size_o, 2);
          chk("req_mode", bus.req_mode_o, cur_mode);
          chk("req_busy", bus.busy_o, 1);
        end
        if (bus.req_ready_i) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (ab_pend) exp_q.delete();
          t_ev = cyc;
        end
      end
      prev_valid = bus.req_valid_o;
      prev_hs = bus.req_valid_o && bus.req_ready_i;
    end
  end
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit m, input int stall,
                     input bit do_abort, input bit do_rst, input bit rnd);
    int st = 0, d0;
    bit hit = 0;
    build(a, b, m);
    cur_mode = m;
    expect_done = 1;
    d0 = dones;
    @(posedge clk); #1;
    bus.start_i = 1;
    bus.desc_addr_i = a;
    bus.desc_bytes_i = b;
    bus.desc_mode_i = m;
    @(posedge clk); #1;
    bus.start_i = 0;
    bus.desc_addr_i = $urandom;
    bus.desc_bytes_i = $urandom;
    bus.desc_mode_i = ~m;
    for (int k = 0; k < 5000 && dones == d0; k++) begin
      bus.abort_i = 0;
      bus.start_i = 0;
      chk("busy_run", bus.busy_o, 1);
      if (!bus.req_valid_o) begin
        st = 0;
        bus.req_ready_i = rnd ? 1'($urandom % 2) : 1'b0;
      end else begin
        bus.req_ready_i = rnd ? ($urandom % 3 != 0) : (st >= stall);
        st++;
      end
      if (bus.req_valid_o && st == 3 && !hit && (do_abort || do_rst)) begin
        hit = 1;
        if (do_rst) begin
          rst = 1;
          bus.req_ready_i = 0;
          break;
        end
        bus.abort_i = 1;
      end
      if (rnd && bus.busy_o) begin
        bus.abort_i = ($urandom % 300 == 0);
        bus.start_i = ($urandom % 40 == 0);
      end
      @(posedge clk); #1;
    end
    bus.req_ready_i = 0;
    bus.abort_i = 0;
    bus.start_i = 0;
    if (do_rst) begin
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rst_valid", bus.req_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      repeat (6) begin
        @(negedge clk);
        chk("rst_no_done", bus.done_o, 0);
      end
      return;
    end
    if (dones == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done_o for addr %0h bytes %0d", a, b);
    end
    @(negedge clk);
    chk("idle_after", bus.busy_o, 0);
  endtask
  initial begin
    logic [31:0] a, b;
    bus.start_i = 0;
    bus.desc_addr_i = 0;
    bus.desc_bytes_i = 0;
    bus.desc_mode_i = 0;
    bus.abort_i = 0;
    bus.req_ready_i = 0;
    build(32'h1000, 64, 1);
    chk("pin1_n", exp_q.size(), 1);
    chk("pin1_r0", pk(exp_q[0]), {32'h1000, 8'd15, 4'hF});
    build(32'h1002, 9, 1);
    chk("pin2_n", exp_q.size(), 3);
    chk("pin2_r0", pk(exp_q[0]), {32'h1000, 8'd0, 4'hC});
    chk("pin2_r1", pk(exp_q[1]), {32'h1004, 8'd0, 4'hF});
    chk("pin2_r2", pk(exp_q[2]), {32'h1008, 8'd0, 4'h7});
    build(32'h1001, 2, 1);
    chk("pin3_r0", pk(exp_q[0]), {32'h1000, 8'd0, 4'h6});
    build(32'h1FF0, 64, 1);
    chk("pin4_r0", pk(exp_q[0]), {32'h1FF0, 8'd3, 4'hF});
    chk("pin4_r1", pk(exp_q[1]), {32'h2000, 8'd11, 4'hF});
    build(32'h1FF0, 64, 0);
    chk("pin4f", pk(exp_q[0]), {32'h1FF0, 8'd15, 4'hF});
    build(32'h0, 200, 1);
    chk("pin5_n", exp_q.size(), 4);
    chk("pin5_r3", pk(exp_q[3]), {32'h0C0, 8'd1, 4'hF});
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_outputs", {bus.busy_o, bus.done_o, bus.req_valid_o, bus.req_addr_o, bus.req_alen_o,
                        bus.req_size_o, bus.req_strb_o, bus.req_mode_o}, 0);
    run(32'h1000, 64, 1, 0, 0, 0, 0);
    run(32'h1002, 9, 1, 0, 0, 0, 0);
    run(32'h1001, 2, 1, 1, 0, 0, 0);
    run(32'h1FF0, 64, 1, 0, 0, 0, 0);
    run(32'h1FF0, 64, 0, 2, 0, 0, 0);
    run(32'h0, 200, 1, 5, 0, 0, 0);
    run(32'h0, 200, 1, 5, 1, 0, 0);
    run(32'h100, 0, 1, 0, 0, 0, 0);
    run(32'h0, 200, 1, 5, 0, 1, 0);
    run(32'h1002, 9, 0, 0, 0, 0, 0);
    run(32'hFFFF_FFF6, 40, 1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 3)
        0: a = $urandom;
        1: a = 32'h0000_1000 * ($urandom % 8 + 1) - $urandom % 80;
        default: a = 32'hFFFF_FFFF - $urandom % 90;
      endcase
      b = ($urandom % 8 == 0) ? 0 : $urandom % 300;
      run(a, b, 1'($urandom % 2), 0, 0, 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_burst_streamer.md
Name: dma_burst_streamer

Overview:
Upstream request generator for the DMA master AXI interface: one instance serves the read side and one the write side.
- Takes a descriptor (start address, byte count, burst mode) from the DMA FSM.
- Splits it into AXI-legal burst requests (address, alen, size, strb, mode) presented over a valid/ready handshake.
- Guarantees every request carries one strobe valid for all its beats. Unaligned head and tail bytes are therefore issued as single-beat bursts.
- No burst crosses a 4 KB boundary or exceeds MAX_BEATS.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, AXI data width in bits; BPB = DATA_W/8 bytes per beat, power of two, 1..128
MAX_BEATS, 16, maximum beats per burst, 1..256
LEN_W, 32, descriptor byte-count width

Ports:
clk  in  1  clock
rst  in  1  reset
start_i  in  1  descriptor valid pulse; sampled only in IDLE
desc_addr_i  in  ADDR_W  descriptor start byte address
desc_bytes_i  in  LEN_W  descriptor byte count
desc_mode_i  in  1  0 = FIXED, 1 = INCR
abort_i  in  1  stop issuing new requests
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse on completion or abort
req_valid_o  out  1  burst request valid
req_addr_o  out  ADDR_W  burst start address, aligned to BPB
req_alen_o  out  8  beats - 1
req_size_o  out  3  log2(BPB)
req_strb_o  out  BPB  byte strobe applied to every beat of the burst
req_mode_o  out  1  copy of latched desc_mode_i
req_ready_i  in  1  downstream accepted the request

Behaviour:
Reset and clock:
- Reset rst, synchronous, active-high; clock clk.
- On reset: state IDLE; all outputs 0; internal address/count registers 0.
- Reset mid-operation abandons the descriptor; req_valid_o is 0 on the cycle after rst is sampled; no done_o is emitted.

State machine IDLE -> CALC -> REQ -> (CALC | DONE) -> IDLE:
- IDLE, start_i=1: latch addr, bytes and mode. bytes == 0 -> DONE, otherwise -> CALC. start_i in any other state is ignored.
- CALC (one cycle): register the next request from cur_addr/bytes_left, with off = cur_addr % BPB.
  - Head (off != 0): n = min(BPB - off, bytes_left); alen 0; strb bits [off .. off+n-1] set; addr = cur_addr aligned down.
  - Tail (off == 0, bytes_left < BPB): n = bytes_left; alen 0; strb bits [0 .. n-1].
  - Body (off == 0, bytes_left >= BPB): beats = min(bytes_left / BPB, MAX_BEATS, (4096 - cur_addr % 4096) / BPB).
    - In FIXED mode the 4 KB term is dropped.
    - strb all ones; n = beats * BPB; alen = beats - 1.
  - abort_i sampled in CALC -> DONE, no request issued.
- REQ: req_valid_o = 1. All req_* outputs are held stable until req_valid_o && req_ready_i.
  - On handshake: bytes_left -= n.
  - INCR: cur_addr += n. FIXED: cur_addr unchanged, including after a head beat.
  - Next state: bytes_left reaches 0 or abort latched -> DONE; otherwise -> CALC.
- DONE: done_o = 1 for exactly one cycle; clear the abort latch; -> IDLE.

Abort:
- abort_i is latched (sticky) in any non-IDLE state.
- It never drops req_valid_o before its handshake.

Latency:
- start_i at cycle T -> req_valid_o at T+2.
- Handshake at T -> next req_valid_o at T+2.
- Last handshake at T -> done_o at T+1.

Arithmetic:
- Address arithmetic wraps modulo 2^ADDR_W.
- bytes_left is never negative because n <= bytes_left.
- The 4 KB term is always >= 1 beat, because addresses are BPB-aligned in the body case.

Test Plan:
1. DATA_W=32, addr 0x1000, bytes 64, INCR -> one request: addr 0x1000, alen 15, size 2, strb 0xF; done_o on the cycle after the handshake.
2. addr 0x1002, bytes 9 -> three requests:
   - 0x1000, alen 0, strb 0xC
   - 0x1004, alen 0, strb 0xF
   - 0x1008, alen 0, strb 0x7
3. addr 0x1001, bytes 2 -> single request: 0x1000, alen 0, strb 0x6.
4. addr 0x1FF0, bytes 64, INCR -> 0x1FF0 alen 3, then 0x2000 alen 11; FIXED mode with the same descriptor -> 0x1FF0 alen 15, addr unchanged.
5. addr 0x0, bytes 200 with req_ready_i low for 5 cycles on each request:
   - Outputs stay stable while stalled.
   - Requests are alen 15, 15, 15, then 1; bytes sum to 200.
   - busy_o is high throughout.
6. Abort while stalled in REQ -> req_valid_o held until the handshake, no further requests, then done_o. bytes=0 -> done_o at T+1 with no request. rst mid-burst -> req_valid_o 0 next cycle and no done_o.
